dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter and access sequencer for the 8-bit data memory. It shares the memory's single read/write port between requester 0 (CPU load/store stage) and requester 1 (DMA/debug port). Each requester uses a req/ack handshake. The block drives the memory's `sigMemRead`, `sigMemWrite`, `dataAddress` and `writeData` from registered grant state, and returns registered read data.

## Interface
- `ADDR_WIDTH`, 8, memory address width
- `DATA_WIDTH`, 8, memory data width
- `clk`  input  1  single clock; all state updates on the rising edge
- `reset`  input  1  asynchronous, active-low reset
- `req0` / `req1`  input  1  access request; held until the matching ack is sampled
- `we0` / `we1`  input  1  1 = write, 0 = read; stable while req is high
- `addr0` / `addr1`  input  ADDR_WIDTH  access address; stable while req is high
- `wdata0` / `wdata1`  input  DATA_WIDTH  write data; stable while req is high
- `ack0` / `ack1`  output  1  one-cycle completion pulse
- `rdata0` / `rdata1`  output  DATA_WIDTH  read result, valid while the matching ack is high; held otherwise
- `sigMemRead`  output  1  memory read strobe
- `sigMemWrite`  output  1  memory write strobe
- `dataAddress`  output  ADDR_WIDTH  memory address
- `writeData`  output  DATA_WIDTH  memory write data
- `readData`  input  DATA_WIDTH  combinational memory read data
- `busy`  output  1  high during an access cycle

## Operation
- State: `IDLE`, `ACC0`, `ACC1`. Exactly one access is in flight per cycle at most.
- **Eligibility.** Port k is eligible at an edge when `req_k`=1, the block is not in `ACCk`, and `ack_k`=0.
- **Grant.** At each edge the block picks one eligible port:
  - Both eligible: round-robin. The grant goes to the port not granted last. The `last` pointer resets to 1, so port 0 wins the first contention.
  - One eligible: that port is granted.
  - None eligible: next state is `IDLE`.
- **Capture on grant.** `we`, `addr` and `wdata` of the granted port are registered into `acc_we`, `acc_addr` and `acc_wdata`. `last` is updated to the granted port.
- **In `ACCk`:**
  - `sigMemRead` = `~acc_we`, `sigMemWrite` = `acc_we`.
  - `dataAddress` = `acc_addr`, `writeData` = `acc_wdata`.
  - `busy` = 1.
- **In `IDLE`:** all memory outputs are 0 and `busy` = 0.
- **Completion.** At the edge that ends `ACCk`:
  - The memory commits the write, if any.
  - `ack_k` is set to 1 for exactly one cycle.
  - For a read, `rdata_k` is loaded from `readData`. For a write, `rdata_k` is unchanged.
  - Grant selection for the next cycle happens at the same edge, per the eligibility rule.
- **Ordering.** A write completed at edge E is visible to any read granted at E or later; there is no stale-data window.
- **Requester protocol errors** (input change while req is high, req dropped before ack) are not checked. Captured values are used; a dropped request still completes and acks.

## Timing
- **Reset (reset=0), asynchronous:**
  - State `IDLE`, `last`=1.
  - `ack0`=`ack1`=0, `rdata0`=`rdata1`=0, `busy`=0.
  - All memory outputs 0, `acc_*` cleared.
- **Reset mid-access:** the access is abandoned, no ack is issued, and all outputs go to their reset values immediately. A write is not committed unless its edge was already taken.
- **Latency.** With req first sampled at edge E0:
  - Access occupies E0→E1.
  - `ack` and `rdata` are high/valid E1→E2.
  - Request-to-ack is 1 cycle after grant (2 edges).
- **Single port, req held continuously:** granted at E0, E3, E6… (one access per 3 cycles), since the port is ineligible while in ACC and while its ack is high.
- **Both ports, req held continuously:** grants 0@E0, 1@E1, idle E2→E3, 0@E3, 1@E4, …
- **Back-to-back handoff:** the other port may be granted at the completion edge, with no idle cycle between accesses.

## Test plan
- **Reset:** assert reset low mid-simulation with req0=1 → all outputs 0 immediately; after release, port 0 granted first.
- **Write then read:**
  - Port 0 writes 0xA5 to 0x10: `sigMemWrite`=1, `dataAddress`=0x10, `writeData`=0xA5 for one cycle, then `ack0` pulse.
  - Port 0 reads 0x10 → `ack0` with `rdata0`=0xA5, `sigMemRead`=1 during the access cycle.
- **Contention:** req0 and req1 rise on the same edge (reads of 0x01 and 0x02) → port 0 served first, port 1 at the next edge; `ack0` then `ack1` on consecutive cycles; `rdata` matches memory contents.
- **Fairness:** both ports hold req for 12 cycles → grant sequence 0,1,−,0,1,−,…; per-port ack counts differ by ≤1.
- **Cross-port coherency:** port 1 writes 0x3C to 0xFF while port 0 requests a read of 0xFF one edge later → port 0 read returns 0x3C.
- **Mid-access reset:** pull reset low during ACC1 for a write of 0x77 to 0x20 → no `ack1`, no write strobe at the next edge; after release, a read of 0x20 returns the pre-write value.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Handshake and memory-port bundle for the two-port data-memory arbiter.
// The master side holds the requesters and the memory. The slave side is the arbiter.
interface dmem_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  req0;
    logic                  req1;
    logic                  we0;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata0;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  ack0;
    logic                  ack1;
    logic [DATA_WIDTH-1:0] rdata0;
    logic [DATA_WIDTH-1:0] rdata1;
    logic                  sigMemRead;
    logic                  sigMemWrite;
    logic [ADDR_WIDTH-1:0] dataAddress;
    logic [DATA_WIDTH-1:0] writeData;
    logic [DATA_WIDTH-1:0] readData;
    logic                  busy;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, readData,
        input  ack0, ack1, rdata0, rdata1, sigMemRead, sigMemWrite,
               dataAddress, writeData, busy
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, readData,
        output ack0, ack1, rdata0, rdata1, sigMemRead, sigMemWrite,
               dataAddress, writeData, busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the 8-bit data memory.
// Each access takes one cycle in ACC0/ACC1. The ack and the read data are registered
// at the edge that ends the access.
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACC0, ACC1} state_t;

    state_t                state;
    state_t                state_next;
    logic                  last;
    logic                  take;
    logic                  sel;
    logic                  elig0;
    logic                  elig1;
    logic                  acc_we;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic                  ack0_q;
    logic                  ack1_q;
    logic [DATA_WIDTH-1:0] rdata0_q;
    logic [DATA_WIDTH-1:0] rdata1_q;

    // Eligibility, round-robin grant selection and next state
    always_comb begin
        // NOTE: every combinational output is defaulted first so no path infers a latch.
        take       = 1'b0;
        sel        = 1'b0;
        state_next = IDLE;
        elig0      = bus.req0 && (state != ACC0) && !ack0_q;
        elig1      = bus.req1 && (state != ACC1) && !ack1_q;
        if (elig0 && elig1) begin
            take = 1'b1;
            sel  = ~last;
        end else if (elig0) begin
            take = 1'b1;
            sel  = 1'b0;
        end else if (elig1) begin
            take = 1'b1;
            sel  = 1'b1;
        end
        if (take) begin
            state_next = sel ? ACC1 : ACC0;
        end
    end

    // State register, capture of the granted request, and completion (ack/rdata)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            last      <= 1'b1;
            acc_we    <= 1'b0;
            acc_addr  <= '0;
            acc_wdata <= '0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments let every flop see the pre-edge values, so the
            // grant decision and the completion of the previous access use the same state.
            state  <= state_next;
            ack0_q <= (state == ACC0);
            ack1_q <= (state == ACC1);
            if (take) begin
                last      <= sel;
                acc_we    <= sel ? bus.we1    : bus.we0;
                acc_addr  <= sel ? bus.addr1  : bus.addr0;
                acc_wdata <= sel ? bus.wdata1 : bus.wdata0;
            end
            if (state == ACC0 && !acc_we) begin
                rdata0_q <= bus.readData;
            end
            if (state == ACC1 && !acc_we) begin
                rdata1_q <= bus.readData;
            end
        end
    end

    // Memory strobes come from registered grant state only and are gated to zero in IDLE
    always_comb begin
        bus.busy        = (state != IDLE);
        bus.sigMemRead  = (state != IDLE) && !acc_we;
        bus.sigMemWrite = (state != IDLE) &&  acc_we;
        bus.dataAddress = (state != IDLE) ? acc_addr  : '0;
        bus.writeData   = (state != IDLE) ? acc_wdata : '0;
    end

    assign bus.ack0   = ack0_q;
    assign bus.ack1   = ack1_q;
    assign bus.rdata0 = rdata0_q;
    assign bus.rdata1 = rdata1_q;
endmodule
